// File: rtl/alu_seq_pkg.sv
// Shared opcode, state and constant definitions for the ALU command sequencer.
package alu_seq_pkg;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_DIV = 2'b10;
   localparam logic [1:0] OP_ILL = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE,
      S_EXEC,
      S_DIV_START,
      S_DIV_WAIT,
      S_RESP
   } state_t;

   // All-ones quotient reported for a divide by zero; users slice to their width.
   localparam logic [63:0] DIV_ZERO_RESULT = '1;

endpackage

// File: rtl/alu_sequencer.sv
// Command front-end for the arithmetic unit and sequential divider: one command
// in flight, divider start/done handshake with timeout, valid/ready response.
module alu_sequencer
   import alu_seq_pkg::*;
#(
   parameter int WIDTH       = 8,
   parameter int DIV_TIMEOUT = 32,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_opcode,
   input  logic [WIDTH-1:0] cmd_a,
   input  logic [WIDTH-1:0] cmd_b,
   output logic [WIDTH-1:0] au_a,
   output logic [WIDTH-1:0] au_b,
   output logic [1:0]       au_op_select,
   input  logic [WIDTH-1:0] au_result,
   output logic             div_start,
   input  logic             div_done,
   input  logic [WIDTH-1:0] div_quot,
   input  logic [WIDTH-1:0] div_rem,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_result,
   output logic [WIDTH-1:0] rsp_rem,
   output logic             rsp_err,
   output logic [CNT_W-1:0] op_count
);

   localparam int TW = $clog2(DIV_TIMEOUT + 1);

   state_t           state, state_nxt;
   logic [WIDTH-1:0] a_q, b_q;
   logic [1:0]       op_q;
   logic [TW-1:0]    tmo_cnt;
   logic             accept;
   logic             tmo_hit;

   assign accept  = cmd_valid && cmd_ready;
   assign tmo_hit = (tmo_cnt == TW'(DIV_TIMEOUT - 1));

   // cmd_ready is gated by rst so nothing looks acceptable while reset is held.
   assign cmd_ready    = rst && (state == S_IDLE);
   assign rsp_valid    = (state == S_RESP);
   assign div_start    = (state == S_DIV_START);
   assign au_a         = a_q;
   assign au_b         = b_q;
   assign au_op_select = op_q;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of process evaluation order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= S_IDLE;
      else      state <= state_nxt;
   end

   // NOTE: state_nxt gets a default before the case so no path infers a latch.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (accept) begin
               case (cmd_opcode)
                  OP_ADD, OP_SUB: state_nxt = S_EXEC;
                  OP_DIV:         state_nxt = (cmd_b != '0) ? S_DIV_START : S_RESP;
                  default:        state_nxt = S_RESP;
               endcase
            end
         end
         S_EXEC:      state_nxt = S_RESP;
         S_DIV_START: state_nxt = S_DIV_WAIT;
         S_DIV_WAIT:  if (div_done || tmo_hit) state_nxt = S_RESP;
         S_RESP:      if (rsp_ready) state_nxt = S_IDLE;
         default:     state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         a_q        <= '0;
         b_q        <= '0;
         op_q       <= '0;
         tmo_cnt    <= '0;
         rsp_result <= '0;
         rsp_rem    <= '0;
         rsp_err    <= 1'b0;
         op_count   <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (accept) begin
                  a_q  <= cmd_a;
                  b_q  <= cmd_b;
                  op_q <= cmd_opcode;
                  if (cmd_opcode == OP_DIV && cmd_b == '0) begin
                     rsp_result <= DIV_ZERO_RESULT[WIDTH-1:0];
                     rsp_rem    <= cmd_a;
                     rsp_err    <= 1'b1;
                  end else if (cmd_opcode == OP_ILL) begin
                     rsp_result <= '0;
                     rsp_rem    <= '0;
                     rsp_err    <= 1'b1;
                  end
               end
            end
            S_EXEC: begin
               rsp_result <= au_result;
               rsp_rem    <= '0;
               rsp_err    <= 1'b0;
            end
            S_DIV_START: tmo_cnt <= '0;
            S_DIV_WAIT: begin
               tmo_cnt <= tmo_cnt + 1'b1;
               // div_done takes priority over a simultaneous timeout.
               if (div_done) begin
                  rsp_result <= div_quot;
                  rsp_rem    <= div_rem;
                  rsp_err    <= 1'b0;
               end else if (tmo_hit) begin
                  rsp_result <= '0;
                  rsp_rem    <= '0;
                  rsp_err    <= 1'b1;
               end
            end
            S_RESP: begin
               if (rsp_ready && op_count != '1) op_count <= op_count + 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: vector table plus hand-written timeout,
// stall and mid-operation reset sequences.
module tb_alu_sequencer;
   import alu_seq_pkg::*;

   localparam int WIDTH       = 8;
   localparam int DIV_TIMEOUT = 32;
   localparam int CNT_W       = 16;

   logic             clk, rst;
   logic             cmd_valid, cmd_ready;
   logic [1:0]       cmd_opcode;
   logic [WIDTH-1:0] cmd_a, cmd_b;
   logic [WIDTH-1:0] au_a, au_b, au_result;
   logic [1:0]       au_op_select;
   logic             div_start, div_done;
   logic [WIDTH-1:0] div_quot, div_rem;
   logic             rsp_valid, rsp_ready;
   logic [WIDTH-1:0] rsp_result, rsp_rem;
   logic             rsp_err;
   logic [CNT_W-1:0] op_count;

   int checks   = 0;
   int failures = 0;
   int exp_cnt  = 0;

   alu_sequencer #(.WIDTH(WIDTH), .DIV_TIMEOUT(DIV_TIMEOUT), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
      .cmd_a(cmd_a), .cmd_b(cmd_b),
      .au_a(au_a), .au_b(au_b), .au_op_select(au_op_select), .au_result(au_result),
      .div_start(div_start), .div_done(div_done), .div_quot(div_quot), .div_rem(div_rem),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
      .rsp_rem(rsp_rem), .rsp_err(rsp_err), .op_count(op_count)
   );

   // Arithmetic unit stand-in: combinational wrap-around add/sub.
   assign au_result = (au_op_select == OP_SUB) ? au_a - au_b : au_a + au_b;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Divider model: done asserted div_lat cycles after the first DIV_WAIT cycle.
   int               div_starts = 0;
   bit               div_en     = 1'b0;
   int               div_lat    = 0;
   logic [WIDTH-1:0] div_q_set  = '0;
   logic [WIDTH-1:0] div_r_set  = '0;
   bit               pending    = 1'b0;
   int               wait_cnt   = 0;

   initial begin
      div_done = 1'b0;
      div_quot = '0;
      div_rem  = '0;
      forever begin
         @(posedge clk);
         #2;
         div_done = 1'b0;
         if (!rst) begin
            pending = 1'b0;
         end else if (div_start) begin
            div_starts++;
            if (div_en) begin
               pending  = 1'b1;
               wait_cnt = div_lat;
            end
         end else if (pending) begin
            if (wait_cnt == 0) begin
               div_done = 1'b1;
               div_quot = div_q_set;
               div_rem  = div_r_set;
               pending  = 1'b0;
            end else begin
               wait_cnt--;
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic present(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
      cmd_opcode = op;
      cmd_a      = a;
      cmd_b      = b;
      cmd_valid  = 1'b1;
      check("cmd_ready_before_accept", cmd_ready, 1);
      tick();
      cmd_valid = 1'b0;
      check("au_a_latched", au_a, a);
      check("au_b_latched", au_b, b);
      check("au_op_latched", au_op_select, op);
   endtask

   task automatic handshake();
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      exp_cnt++;
      check("op_count", op_count, exp_cnt);
      check("rsp_valid_drop", rsp_valid, 0);
      check("cmd_ready_after_rsp", cmd_ready, 1);
   endtask

   typedef struct {
      logic [1:0] op;
      logic [7:0] a, b;
      int         lat;
      logic [7:0] dq, dr;
      logic [7:0] exp_res, exp_rem;
      logic       exp_err;
      int         exp_starts;
   } vec_t;

   vec_t vecs[8];

   task automatic run_vec(input vec_t v);
      int s0;
      int n;
      s0        = div_starts;
      div_en    = 1'b1;
      div_lat   = v.lat;
      div_q_set = v.dq;
      div_r_set = v.dr;
      present(v.op, v.a, v.b);
      if (v.op == OP_ADD || v.op == OP_SUB) begin
         check("addsub_valid_edge1", rsp_valid, 0);
         tick();
         check("addsub_valid_edge2", rsp_valid, 1);
      end
      n = 0;
      while (!rsp_valid && n < 200) begin
         tick();
         n++;
      end
      check("rsp_valid_seen", rsp_valid, 1);
      check("rsp_result", rsp_result, v.exp_res);
      check("rsp_rem", rsp_rem, v.exp_rem);
      check("rsp_err", rsp_err, v.exp_err);
      check("div_start_pulses", div_starts - s0, v.exp_starts);
      handshake();
   endtask

   initial begin
      int s0;
      rst        = 1'b0;
      cmd_valid  = 1'b0;
      cmd_opcode = '0;
      cmd_a      = '0;
      cmd_b      = '0;
      rsp_ready  = 1'b0;

      vecs[0] = '{OP_ADD, 8'd200, 8'd100, 0, 8'd0,  8'd0, 8'd44,  8'd0,  1'b0, 0};
      vecs[1] = '{OP_SUB, 8'd5,   8'd9,   0, 8'd0,  8'd0, 8'd252, 8'd0,  1'b0, 0};
      vecs[2] = '{OP_ADD, 8'd255, 8'd1,   0, 8'd0,  8'd0, 8'd0,   8'd0,  1'b0, 0};
      vecs[3] = '{OP_SUB, 8'd100, 8'd30,  0, 8'd0,  8'd0, 8'd70,  8'd0,  1'b0, 0};
      vecs[4] = '{OP_DIV, 8'd100, 8'd7,   8, 8'd14, 8'd2, 8'd14,  8'd2,  1'b0, 1};
      vecs[5] = '{OP_DIV, 8'd55,  8'd0,   0, 8'd0,  8'd0, 8'hFF,  8'd55, 1'b1, 0};
      vecs[6] = '{OP_ILL, 8'd3,   8'd4,   0, 8'd0,  8'd0, 8'd0,   8'd0,  1'b1, 0};
      vecs[7] = '{OP_DIV, 8'd200, 8'd16,  0, 8'd12, 8'd8, 8'd12,  8'd8,  1'b0, 1};

      // Reset state.
      repeat (2) @(negedge clk);
      check("rst_cmd_ready", cmd_ready, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_div_start", div_start, 0);
      check("rst_op_count", op_count, 0);
      check("rst_au_a", au_a, 0);
      rst = 1'b1;
      tick();
      check("idle_cmd_ready", cmd_ready, 1);

      for (int i = 0; i < 8; i++) run_vec(vecs[i]);

      // Divider never finishes: timeout response DIV_TIMEOUT cycles after DIV_WAIT entry.
      s0     = div_starts;
      div_en = 1'b0;
      present(OP_DIV, 8'd9, 8'd3);
      check("tmo_div_start", div_start, 1);
      tick();
      repeat (DIV_TIMEOUT - 1) tick();
      check("tmo_not_early", rsp_valid, 0);
      tick();
      check("tmo_valid", rsp_valid, 1);
      check("tmo_err", rsp_err, 1);
      check("tmo_result", rsp_result, 0);
      check("tmo_rem", rsp_rem, 0);
      check("tmo_pulses", div_starts - s0, 1);
      handshake();

      // div_done on the expiry cycle wins over the timeout.
      s0        = div_starts;
      div_en    = 1'b1;
      div_lat   = DIV_TIMEOUT - 1;
      div_q_set = 8'd3;
      div_r_set = 8'd0;
      present(OP_DIV, 8'd9, 8'd3);
      tick();
      repeat (DIV_TIMEOUT - 1) tick();
      check("race_not_early", rsp_valid, 0);
      tick();
      check("race_valid", rsp_valid, 1);
      check("race_err", rsp_err, 0);
      check("race_result", rsp_result, 3);
      check("race_pulses", div_starts - s0, 1);
      handshake();

      // Response back-pressure with a competing command held on the input.
      present(OP_SUB, 8'd5, 8'd9);
      cmd_opcode = OP_ADD;
      cmd_a      = 8'd1;
      cmd_b      = 8'd1;
      cmd_valid  = 1'b1;
      tick();
      for (int i = 0; i < 10; i++) begin
         check("stall_valid", rsp_valid, 1);
         check("stall_result", rsp_result, 252);
         check("stall_cmd_ready", cmd_ready, 0);
         tick();
      end
      cmd_valid = 1'b0;
      check("stall_au_a_kept", au_a, 5);
      handshake();

      // Reset asserted mid-DIV_WAIT.
      s0     = div_starts;
      div_en = 1'b0;
      present(OP_DIV, 8'd50, 8'd5);
      repeat (5) tick();
      rst = 1'b0;
      #1;
      check("mid_rst_cmd_ready", cmd_ready, 0);
      check("mid_rst_div_start", div_start, 0);
      check("mid_rst_rsp_valid", rsp_valid, 0);
      check("mid_rst_op_count", op_count, 0);
      check("mid_rst_au_a", au_a, 0);
      check("mid_rst_au_b", au_b, 0);
      check("mid_rst_au_op", au_op_select, 0);
      check("mid_rst_result", rsp_result, 0);
      check("mid_rst_rem", rsp_rem, 0);
      check("mid_rst_err", rsp_err, 0);
      @(posedge clk);
      @(negedge clk);
      rst     = 1'b1;
      exp_cnt = 0;
      repeat (40) tick();
      check("post_rst_no_start", div_starts - s0, 1);
      check("post_rst_idle", cmd_ready, 1);
      check("post_rst_no_rsp", rsp_valid, 0);

      run_vec(vecs[0]);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got 1 expected 0");
      $fatal(1, "bench time limit");
   end

endmodule
